// File: rtl/multi_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module      : multi_debounce_if
//  Description : Pin-side and control-side signal bundle for multi_debounce.
//                The master drives the raw pin levels. The slave (the
//                debouncer) returns the cleaned levels and the event pulses.
//  Revision    : 1.0  initial release
// ============================================================================
interface multi_debounce_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] noisy;      // raw pin levels
    logic [CHANNELS-1:0] debounced;  // cleaned level, 1 = pressed
    logic [CHANNELS-1:0] rise;       // one-cycle press pulse
    logic [CHANNELS-1:0] fall;       // one-cycle release pulse
    logic [CHANNELS-1:0] rpt;        // press pulse plus auto-repeat pulses

    modport master (
        output noisy,
        input  debounced,
        input  rise,
        input  fall,
        input  rpt
    );

    modport slave (
        input  noisy,
        output debounced,
        output rise,
        output fall,
        output rpt
    );
endinterface
`default_nettype wire

// File: rtl/multi_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : multi_debounce
//  Description : Multi-channel button/switch debouncer. Each channel has a
//                two-flop synchroniser, a saturating stability counter, a
//                debounced level and press/release pulses. An optional
//                auto-repeat generator is provided for held buttons.
//  Revision    : 1.0  initial release
// ============================================================================
module multi_debounce #(
    parameter int CHANNELS   = 4,
    parameter int DELAY      = 500000,
    parameter int ACTIVE_LOW = 1,
    parameter int REPEAT_EN  = 0,
    parameter int HOLD       = 25000000,
    parameter int RPT_PERIOD = 5000000
) (
    input  wire logic       CLOCK_50,
    input  wire logic       reset_n,
    multi_debounce_if.slave bus
);

    // Stability counter saturates at DELAY, so it needs to hold DELAY itself.
    localparam int              c_CW    = $clog2(DELAY + 1);
    localparam logic [c_CW-1:0] c_DELAY = c_CW'(DELAY);

    logic [CHANNELS-1:0] w_x;
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;
    logic [CHANNELS-1:0] w_deb_next;
    logic [CHANNELS-1:0] r_debounced;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic [CHANNELS-1:0] w_rpt;

    // Outputs are always active-high "pressed", whatever the pin polarity.
    assign w_x = (ACTIVE_LOW != 0) ? ~bus.noisy : bus.noisy;

    // Two-flop synchroniser bringing the pin levels into the clock domain.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_x;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic            r_cand;
        logic [c_CW-1:0] r_cnt;

        // Track the candidate level; any change restarts the stability count,
        // which then counts up and saturates at DELAY.
        always_ff @(posedge CLOCK_50 or negedge reset_n) begin
            if (!reset_n) begin
                r_cand <= 1'b0;
                r_cnt  <= '0;
            end else if (r_sync2[g] != r_cand) begin
                r_cand <= r_sync2[g];
                r_cnt  <= '0;
            end else if (r_cnt != c_DELAY) begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end

        // The candidate is committed only once it has been stable long enough.
        assign w_deb_next[g] = ((r_sync2[g] == r_cand) && (r_cnt == c_DELAY))
                               ? r_cand : r_debounced[g];
    end

    // Register the debounced level and derive the edge pulses on the same edge.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_debounced <= '0;
            r_rise      <= '0;
            r_fall      <= '0;
        end else begin
            r_debounced <= w_deb_next;
            r_rise      <= w_deb_next & ~r_debounced;
            r_fall      <= ~w_deb_next & r_debounced;
        end
    end

    if (REPEAT_EN != 0) begin : g_repeat
        // Hold counter counts cycles within the current hold or repeat period.
        localparam int              c_HMAX = (HOLD > RPT_PERIOD) ? HOLD : RPT_PERIOD;
        localparam int              c_HW   = $clog2(c_HMAX + 1);
        localparam logic [c_HW-1:0] c_HOLD = c_HW'(HOLD);
        localparam logic [c_HW-1:0] c_RPT  = c_HW'(RPT_PERIOD);
        localparam logic [c_HW-1:0] c_ONE  = c_HW'(1);

        localparam logic [1:0] c_S_IDLE      = 2'd0;
        localparam logic [1:0] c_S_HOLDING   = 2'd1;
        localparam logic [1:0] c_S_REPEATING = 2'd2;

        for (genvar g = 0; g < CHANNELS; g++) begin : g_rch
            logic [1:0]      r_state;
            logic [1:0]      w_state_next;
            logic [c_HW-1:0] r_hcnt;
            logic [c_HW-1:0] w_hcnt_next;
            logic            r_rpt;
            logic            w_rpt_next;
            logic            w_rise_next;
            logic            w_period_done;

            assign w_rise_next   = w_deb_next[g] & ~r_debounced[g];
            assign w_period_done = ((r_state == c_S_HOLDING)   && (r_hcnt == c_HOLD)) ||
                                   ((r_state == c_S_REPEATING) && (r_hcnt == c_RPT));

            // State, hold counter and repeat pulse registers.
            always_ff @(posedge CLOCK_50 or negedge reset_n) begin
                if (!reset_n) begin
                    r_state <= c_S_IDLE;
                    r_hcnt  <= '0;
                    r_rpt   <= 1'b0;
                end else begin
                    r_state <= w_state_next;
                    r_hcnt  <= w_hcnt_next;
                    r_rpt   <= w_rpt_next;
                end
            end

            // Next state: a release always wins and returns to idle at once.
            always_comb begin
                w_state_next = r_state;
                if (!w_deb_next[g]) begin
                    w_state_next = c_S_IDLE;
                end else if (w_rise_next) begin
                    w_state_next = c_S_HOLDING;
                end else if ((r_state == c_S_HOLDING) && (r_hcnt == c_HOLD)) begin
                    w_state_next = c_S_REPEATING;
                end
            end

            // Counter and pulse: pulse on the press itself and at each period end.
            always_comb begin
                w_hcnt_next = r_hcnt;
                w_rpt_next  = 1'b0;
                if (!w_deb_next[g]) begin
                    w_hcnt_next = '0;
                end else if (w_rise_next) begin
                    w_hcnt_next = c_ONE;
                    w_rpt_next  = 1'b1;
                end else if (w_period_done) begin
                    w_hcnt_next = c_ONE;
                    w_rpt_next  = 1'b1;
                end else if (r_state != c_S_IDLE) begin
                    w_hcnt_next = r_hcnt + 1'b1;
                end
            end

            assign w_rpt[g] = r_rpt;
        end
    end else begin : g_no_repeat
        assign w_rpt = r_rise;
    end

    assign bus.debounced = r_debounced;
    assign bus.rise      = r_rise;
    assign bus.fall      = r_fall;
    assign bus.rpt       = w_rpt;

endmodule
`default_nettype wire

// File: tb/tb_multi_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_debounce
//  Description : Self-checking bench for multi_debounce (4 channels, DELAY=4,
//                HOLD=10, RPT_PERIOD=3, active-low pins, auto-repeat on).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multi_debounce;

    localparam int CH    = 4;
    localparam int DLY   = 4;
    localparam int HLD   = 10;
    localparam int RPER  = 3;

    logic CLOCK_50;
    logic reset_n;

    multi_debounce_if #(.CHANNELS(CH)) bus ();

    multi_debounce #(
        .CHANNELS   (CH),
        .DELAY      (DLY),
        .ACTIVE_LOW (1),
        .REPEAT_EN  (1),
        .HOLD       (HLD),
        .RPT_PERIOD (RPER)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    // The debounced level becomes v once the pressed-level samples taken at
    // edges n-DLY-3 .. n-2 all equal v (two edges of synchroniser delay plus
    // DLY+2 consecutive equal samples). Repeat pulses are cycles-since-rise
    // arithmetic: t==0, or t>=HOLD with (t-HOLD) a multiple of RPT_PERIOD.
    logic [CH-1:0] m_hist[$];
    logic [CH-1:0] m_deb, m_rise, m_fall, m_rpt;
    int            m_t[CH];

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < DLY + 4; i++) m_hist.push_back('0);
        m_deb = '0; m_rise = '0; m_fall = '0; m_rpt = '0;
        for (int c = 0; c < CH; c++) m_t[c] = -1;
    endfunction

    function automatic void model_edge(logic [CH-1:0] x);
        logic [CH-1:0] nd;
        m_hist.push_back(x);
        void'(m_hist.pop_front());
        nd = m_deb;
        for (int c = 0; c < CH; c++) begin
            int ones;
            ones = 0;
            for (int k = 0; k < DLY + 2; k++) ones += int'(m_hist[k][c]);
            if (ones == DLY + 2) nd[c] = 1'b1;
            else if (ones == 0)  nd[c] = 1'b0;
        end
        m_rise = nd & ~m_deb;
        m_fall = ~nd & m_deb;
        for (int c = 0; c < CH; c++) begin
            if (!nd[c])       m_t[c] = -1;
            else if (m_rise[c]) m_t[c] = 0;
            else              m_t[c] = m_t[c] + 1;
            m_rpt[c] = nd[c] && ((m_t[c] == 0) ||
                       (m_t[c] >= HLD && ((m_t[c] - HLD) % RPER) == 0));
        end
        m_deb = nd;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(string name, logic [CH-1:0] act, logic [CH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(string name);
        n_checks++;
        if ({bus.debounced, bus.rise, bus.fall, bus.rpt} !== {m_deb, m_rise, m_fall, m_rpt}) begin
            n_fail++;
            $display("FAIL %s: got deb/rise/fall/rpt %b/%b/%b/%b, expected %b/%b/%b/%b (t=%0t)",
                     name, bus.debounced, bus.rise, bus.fall, bus.rpt,
                     m_deb, m_rise, m_fall, m_rpt, $time);
        end
    endtask

    // One clock edge; model sees the pin level present at that edge.
    task automatic tick();
        logic [CH-1:0] x_pre;
        x_pre = ~bus.noisy;
        @(posedge CLOCK_50);
        if (!reset_n) model_reset();
        else          model_edge(x_pre);
        #1;
    endtask

    task automatic step(string name);
        tick();
        check_model(name);
    endtask

    task automatic steps(string name, int n);
        for (int i = 0; i < n; i++) step(name);
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic [CH-1:0] noisy;
        logic [7:0]    n;
        logic [CH-1:0] deb;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic [CH-1:0] rpt;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int rises;
        int found;

        // ch0 press (+repeats), ch2 short glitch, ch1 press, swap, releases
        tbl[0]  = '{4'b1110, 8'd7, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b1110, 8'd1, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
        tbl[2]  = '{4'b1110, 8'd1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b1010, 8'd4, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b1110, 8'd5, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
        tbl[5]  = '{4'b1110, 8'd1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b1110, 8'd2, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
        tbl[7]  = '{4'b1100, 8'd7, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b1100, 8'd1, 4'b0011, 4'b0010, 4'b0000, 4'b0010};
        tbl[9]  = '{4'b1101, 8'd7, 4'b0011, 4'b0000, 4'b0000, 4'b0001};
        tbl[10] = '{4'b1101, 8'd1, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
        tbl[11] = '{4'b1110, 8'd7, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        tbl[12] = '{4'b1110, 8'd1, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
        tbl[13] = '{4'b1111, 8'd8, 4'b0000, 4'b0000, 4'b0001, 4'b0000};

        // ---- reset behaviour ----
        model_reset();
        reset_n   = 1'b0;
        bus.noisy = 4'b1111;
        steps("in_reset", 3);
        check("reset_deb",  bus.debounced, 4'b0000);
        check("reset_puls", bus.rise | bus.fall | bus.rpt, 4'b0000);
        reset_n   = 1'b1;
        bus.noisy = 4'b0000;
        steps("all_press", 12);
        check("all_press_deb", bus.debounced, 4'b1111);
        // asynchronous assertion between edges
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_deb",  bus.debounced, 4'b0000);
        check("async_rst_puls", bus.rise | bus.fall | bus.rpt, 4'b0000);
        steps("held_reset", 20);
        reset_n = 1'b1;
        steps("post_rst", 7);
        check("post_rst_deb7", bus.debounced, 4'b0000);
        step("post_rst");
        check("post_rst_deb8",  bus.debounced, 4'b1111);
        check("post_rst_rise8", bus.rise, 4'b1111);
        check("post_rst_rpt8",  bus.rpt, 4'b1111);
        step("post_rst");
        check("post_rst_rise9", bus.rise, 4'b0000);
        bus.noisy = 4'b1111;
        steps("all_release", 14);
        check("all_release_deb", bus.debounced, 4'b0000);

        // ---- table-driven vectors ----
        for (int i = 0; i < 14; i++) begin
            bus.noisy = tbl[i].noisy;
            for (int k = 0; k < int'(tbl[i].n); k++) tick();
            check($sformatf("tbl%0d_deb",  i), bus.debounced, tbl[i].deb);
            check($sformatf("tbl%0d_rise", i), bus.rise,      tbl[i].rise);
            check($sformatf("tbl%0d_fall", i), bus.fall,      tbl[i].fall);
            check($sformatf("tbl%0d_rpt",  i), bus.rpt,       tbl[i].rpt);
        end

        // ---- bounce on ch1 ----
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            bus.noisy[1] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step("bounce");
            check("bounce_deb1", {3'b000, bus.debounced[1]}, 4'b0000);
            rises += int'(bus.rise[1]);
        end
        bus.noisy[1] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step("settle");
            rises += int'(bus.rise[1]);
        end
        check("settle_deb7", bus.debounced, 4'b0000);
        step("settle");
        rises += int'(bus.rise[1]);
        check("settle_deb8",  bus.debounced, 4'b0010);
        check("settle_rise8", bus.rise, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            step("settle");
            rises += int'(bus.rise[1]);
        end
        n_checks++;
        if (rises != 1) begin
            n_fail++;
            $display("FAIL bounce_rise_count: got %0d, expected 1", rises);
        end
        bus.noisy = 4'b1111;
        steps("bounce_release", 12);

        // ---- auto-repeat on ch3 ----
        bus.noisy = 4'b0111;
        found = 0;
        for (int i = 1; i <= 20 && found == 0; i++) begin
            step("rpt_press");
            if (bus.rise[3]) found = i;
        end
        n_checks++;
        if (found != 8) begin
            n_fail++;
            $display("FAIL rpt_rise_edge: got edge %0d, expected 8", found);
        end
        check("rpt_at_rise", bus.rpt, 4'b1000);
        for (int k = 1; k <= 30; k++) begin
            logic e;
            e = (k >= HLD) && (((k - HLD) % RPER) == 0);
            step("rpt_hold");
            check($sformatf("rpt_hold_%0d", k), bus.rpt, {e, 3'b000});
        end
        bus.noisy = 4'b1111;
        steps("rpt_release", 7);
        step("rpt_release");
        check("rpt_fall",       bus.fall, 4'b1000);
        check("rpt_fall_norpt", bus.rpt,  4'b0000);
        for (int k = 0; k < 6; k++) begin
            step("rpt_after");
            check("rpt_after_norpt", bus.rpt, 4'b0000);
        end

        // ---- randomized stimulus against the model ----
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < CH; ch++)
                if ($urandom_range(0, 5) == 0) bus.noisy[ch] = ~bus.noisy[ch];
            if (c == 1500) begin
                reset_n = 1'b0;
                model_reset();
                #1;
                check("rand_async_rst", bus.debounced | bus.rise | bus.fall | bus.rpt, 4'b0000);
                steps("rand_reset", 3);
                reset_n = 1'b1;
            end
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_debounce.md
Name: multi_debounce

Overview:
- Parametrised, multi-channel successor to the single-input debouncer, for the board's buttons and switches (e.g. KEY[3:0] paddle controls).
- Per channel: a two-flop synchroniser, a stability counter and a debounced level output.
- Also per channel: one-cycle press/release pulses and an optional auto-repeat pulse for held buttons.
- Sits between board pins and the game control logic, all in the CLOCK_50 domain.

Parameters:
- CHANNELS, 4: number of independent input channels (1..32).
- DELAY, 500000: stable cycles required before the output changes (10 ms at 50 MHz); must be >= 1.
- ACTIVE_LOW, 1: 1 = pins are active-low (DE-board KEYs), so inputs are inverted before synchronisation; outputs are always active-high "pressed".
- REPEAT_EN, 0: 1 = enable auto-repeat on rpt.
- HOLD, 25000000: cycles a debounced level must stay high before the first repeat pulse (500 ms).
- RPT_PERIOD, 5000000: cycles between subsequent repeat pulses (100 ms).
- Counter widths are derived internally with $clog2 of (DELAY+1), HOLD and RPT_PERIOD.

Ports:
- CLOCK_50  in  1  system clock, all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- noisy  in  CHANNELS  raw pin levels.
- debounced  out  CHANNELS  debounced level, 1 = pressed.
- rise  out  CHANNELS  one-cycle pulse when debounced goes 0->1.
- fall  out  CHANNELS  one-cycle pulse when debounced goes 1->0.
- rpt  out  CHANNELS  one-cycle pulse: equals rise, plus auto-repeat pulses when REPEAT_EN=1.

Behaviour:
- Reset (reset_n=0, asynchronous): synchronisers, candidate, counters, debounced, rise, fall and rpt all clear to 0 immediately, with no clock needed.
- Release is synchronous to CLOCK_50 at the board level. A held (pressed) input after reset goes through the full debounce delay before debounced asserts.
- Input conditioning: x = ACTIVE_LOW ? ~noisy : noisy, then s = two-flop synchronised x.
- Per channel, on each rising edge, evaluated in priority order:
  - s != cand: cand <= s, cnt <= 0.
  - else cnt != DELAY: cnt <= cnt + 1.
  - else (cnt == DELAY): debounced <= cand; cnt holds at DELAY (saturates, no wrap).
- Any glitch restarts the count. A glitch shorter than DELAY+1 cycles never reaches debounced.
- Latency: a clean level change on noisy appears on debounced at the (DELAY+4)th rising edge. Edge 1 is the first edge that samples the new level.
- rise/fall are registered on the same edge that updates debounced:
  - rise = 1 for exactly the first cycle debounced reads 1.
  - fall = 1 for exactly the first cycle debounced reads 0.
  - rise and fall are never high together on one channel.
- Auto-repeat (REPEAT_EN=1), per channel:
  - States: IDLE, HOLDING, REPEATING. Each state is a function of debounced and hcnt.
  - IDLE: debounced=0, hcnt=0.
  - On rise -> HOLDING with hcnt=1, incrementing each cycle.
  - HOLDING, hcnt == HOLD: rpt pulses, hcnt <= 1 -> REPEATING.
  - REPEATING, hcnt == RPT_PERIOD: rpt pulses, hcnt <= 1.
  - debounced=0 in any state -> IDLE immediately (same edge as fall), with no further rpt.
  - rpt also pulses on the rise cycle. The first repeat pulse is therefore HOLD cycles after rise.
- REPEAT_EN=0: rpt == rise, and the hold counter logic is removed.
- Channels are fully independent. Simultaneous events on different channels are each handled in full.
- Reset asserted mid-count or mid-repeat aborts everything to the reset state, with no pulse emitted.

Test Plan (CHANNELS=4, DELAY=4, HOLD=10, RPT_PERIOD=3, ACTIVE_LOW=1):
- Reset behaviour: assert reset_n=0 mid-run, with noisy=4'b0000 (all pressed) for 20 cycles -> all outputs 0 asynchronously, before the next edge. Release -> debounced=4'b1111 at edge 8 after release, rise=4'b1111 for one cycle.
- Clean press on ch0 (noisy[0] 1->0) -> debounced[0] rises at edge 8, rise[0] one cycle, fall=0, other channels unchanged.
- Bounce on ch1: noisy[1] toggles every 2 cycles for 20 cycles, then settles low -> debounced[1] stays 0 during bounce and rises 8 edges after the final transition. Exactly one rise[1] pulse.
- Short glitch on ch2: noisy[2] low for 4 cycles, then high -> debounced[2] never changes, no rise/fall.
- Repeat (REPEAT_EN=1) on ch3: hold pressed 30 cycles after rise -> rpt[3] at rise cycle, then +10, +13, +16, ... On release -> fall[3] pulse, no rpt after the release edge.
- Simultaneous: ch0 press and ch1 release on the same cycle -> rise[0] and fall[1] pulse on the same edge, independent of each other.
